// File: rtl/audio_pkg.sv
// Shared audio definitions for the SD-card loader and the I2S player:
// loader state encoding, SDRAM base address and WAV header magic.
package audio_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HEADER,
      ST_LO,
      ST_HI,
      ST_WR_REQ,
      ST_WR_WAIT,
      ST_DONE
   } loader_state_t;

   localparam logic [24:0] AUDIO_BASE_ADDR   = 25'h80000;
   localparam int          WAV_HDR_BYTES     = 44;
   localparam int          AUDIO_MAX_SAMPLES = 2**21;

   // ASCII tags, first character in the most significant byte
   localparam logic [31:0] RIFF_MAGIC = 32'h52494646;
   localparam logic [31:0] WAVE_MAGIC = 32'h57415645;

   function automatic logic [7:0] magicByte(input logic [31:0] magic, input logic [1:0] pos);
      logic [7:0] b;
      case (pos)
         2'd0:    b = magic[31:24];
         2'd1:    b = magic[23:16];
         2'd2:    b = magic[15:8];
         default: b = magic[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/wav_hdr_check.sv
// WAV header inspection: flags a byte that breaks the RIFF/WAVE tags and
// captures the little-endian data length from the last four header bytes.
module wav_hdr_check
   import audio_pkg::*;
#(
   parameter int HDR_BYTES = WAV_HDR_BYTES,
   parameter int IDX_W     = 6
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             clear_i,
   input  logic             xfer_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [7:0]       byte_i,
   output logic             mismatch_o,
   output logic [31:0]      dataLenNext_o,
   output logic [31:0]      dataLen_o
);

   localparam int LEN_POS = HDR_BYTES - 4;

   logic [31:0] dataLen_q, dataLen_d;
   logic [1:0]  lenSel;
   logic        inLenField;

   assign inLenField = (idx_i >= IDX_W'(LEN_POS)) && (idx_i < IDX_W'(HDR_BYTES));
   assign lenSel     = 2'(idx_i - IDX_W'(LEN_POS));

   // Length bytes arrive LSB first; the merged value is exposed so the loader
   // can decide on an empty file in the same cycle as the last header byte.
   always_comb begin
      dataLen_d = dataLen_q;
      if (xfer_i && inLenField) begin
         dataLen_d[{lenSel, 3'b000} +: 8] = byte_i;
      end
   end

   always_comb begin
      mismatch_o = 1'b0;
      if (idx_i < IDX_W'(4)) begin
         mismatch_o = (byte_i != magicByte(RIFF_MAGIC, idx_i[1:0]));
      end else if ((idx_i >= IDX_W'(8)) && (idx_i < IDX_W'(12))) begin
         mismatch_o = (byte_i != magicByte(WAVE_MAGIC, idx_i[1:0]));
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i || clear_i) begin
         dataLen_q <= '0;
      end else begin
         dataLen_q <= dataLen_d;
      end
   end

   assign dataLenNext_o = dataLen_d;
   assign dataLen_o     = dataLen_q;

endmodule

// File: rtl/audio_sdram_loader.sv
// Streams a WAV file into SDRAM: validates and strips the header, packs
// little-endian 16-bit PCM samples and writes one word per address.
module audio_sdram_loader
   import audio_pkg::*;
#(
   parameter logic [24:0] BASE_ADDR   = AUDIO_BASE_ADDR,
   parameter int          HDR_BYTES   = WAV_HDR_BYTES,
   parameter int          MAX_SAMPLES = AUDIO_MAX_SAMPLES
) (
   input  logic        Clk50,
   input  logic        reset,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   input  logic        sdram_Wait,
   input  logic        sdram_ac,
   output logic        sdram_wr,
   output logic [24:0] sdram_addr,
   output logic [15:0] sdram_wdata,
   output logic        busy,
   output logic        load_done,
   output logic        hdr_err,
   output logic [24:0] end_addr
);

   localparam int               IDX_W    = $clog2(HDR_BYTES + 1);
   localparam logic [IDX_W-1:0] LAST_HDR = IDX_W'(HDR_BYTES - 1);
   localparam logic [21:0]      WORD_CAP = 22'(MAX_SAMPLES);

   loader_state_t    state_q;
   logic [IDX_W-1:0] hdrCnt_q;
   logic [31:0]      dataCnt_q;
   logic [21:0]      words_q;
   logic             byteReady_q;
   logic             sdramWr_q;
   logic [24:0]      addr_q;
   logic [15:0]      wdata_q;
   logic             busy_q;
   logic             loadDone_q;
   logic             hdrErr_q;
   logic [24:0]      endAddr_q;

   logic        byteXfer;
   logic        startAccept;
   logic        hdrMismatch;
   logic [31:0] dataLen;
   logic [31:0] dataLenNext;

   assign byteXfer    = byte_valid && byteReady_q;
   assign startAccept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   wav_hdr_check #(
      .HDR_BYTES (HDR_BYTES),
      .IDX_W     (IDX_W)
   ) u_hdrCheck (
      .clk_i         (Clk50),
      .reset_i       (reset),
      .clear_i       (startAccept),
      .xfer_i        (byteXfer && (state_q == ST_HEADER)),
      .idx_i         (hdrCnt_q),
      .byte_i        (byte_data),
      .mismatch_o    (hdrMismatch),
      .dataLenNext_o (dataLenNext),
      .dataLen_o     (dataLen)
   );

   // All outputs are registered and change together with the state, so the
   // SDRAM request, address and data are always mutually consistent.
   always_ff @(posedge Clk50) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         hdrCnt_q    <= '0;
         dataCnt_q   <= '0;
         words_q     <= '0;
         byteReady_q <= 1'b0;
         sdramWr_q   <= 1'b0;
         addr_q      <= BASE_ADDR;
         wdata_q     <= '0;
         busy_q      <= 1'b0;
         loadDone_q  <= 1'b0;
         hdrErr_q    <= 1'b0;
         endAddr_q   <= BASE_ADDR;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_q     <= ST_HEADER;
                  hdrCnt_q    <= '0;
                  dataCnt_q   <= '0;
                  words_q     <= '0;
                  addr_q      <= BASE_ADDR;
                  loadDone_q  <= 1'b0;
                  hdrErr_q    <= 1'b0;
                  byteReady_q <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end

            ST_HEADER: begin
               if (byteXfer) begin
                  hdrCnt_q <= hdrCnt_q + 1'b1;
                  if (hdrMismatch) begin
                     state_q     <= ST_DONE;
                     hdrErr_q    <= 1'b1;
                     byteReady_q <= 1'b0;
                     busy_q      <= 1'b0;
                  end else if (hdrCnt_q == LAST_HDR) begin
                     if (dataLenNext == '0) begin
                        state_q     <= ST_DONE;
                        loadDone_q  <= 1'b1;
                        endAddr_q   <= BASE_ADDR;
                        byteReady_q <= 1'b0;
                        busy_q      <= 1'b0;
                     end else begin
                        state_q   <= ST_LO;
                        dataCnt_q <= '0;
                     end
                  end
               end
            end

            // An odd-length file ends on a low byte; its high byte is zero.
            ST_LO: begin
               if (byteXfer) begin
                  wdata_q[7:0] <= byte_data;
                  dataCnt_q    <= dataCnt_q + 32'd1;
                  if (dataCnt_q + 32'd1 == dataLen) begin
                     wdata_q[15:8] <= 8'h00;
                     state_q       <= ST_WR_REQ;
                     byteReady_q   <= 1'b0;
                  end else begin
                     state_q <= ST_HI;
                  end
               end
            end

            ST_HI: begin
               if (byteXfer) begin
                  wdata_q[15:8] <= byte_data;
                  dataCnt_q     <= dataCnt_q + 32'd1;
                  state_q       <= ST_WR_REQ;
                  byteReady_q   <= 1'b0;
               end
            end

            ST_WR_REQ: begin
               if (!sdram_Wait) begin
                  sdramWr_q <= 1'b1;
                  state_q   <= ST_WR_WAIT;
               end
            end

            ST_WR_WAIT: begin
               if (sdram_ac) begin
                  sdramWr_q <= 1'b0;
                  addr_q    <= addr_q + 25'd1;
                  words_q   <= words_q + 22'd1;
                  if ((dataCnt_q == dataLen) || (words_q + 22'd1 == WORD_CAP)) begin
                     state_q    <= ST_DONE;
                     endAddr_q  <= addr_q + 25'd1;
                     loadDone_q <= 1'b1;
                     busy_q     <= 1'b0;
                  end else begin
                     state_q     <= ST_LO;
                     byteReady_q <= 1'b1;
                  end
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign byte_ready  = byteReady_q;
   assign sdram_wr    = sdramWr_q;
   assign sdram_addr  = addr_q;
   assign sdram_wdata = wdata_q;
   assign busy        = busy_q;
   assign load_done   = loadDone_q;
   assign hdr_err     = hdrErr_q;
   assign end_addr    = endAddr_q;

endmodule
